// File: rtl/cmpmul_acc_collector.sv
// Sums every NACC complex products from a non-stallable valid-only stream and
// queues the finished sums in a small FWFT FIFO behind an AXI-Stream master.
module cmpmul_acc_collector #(
  parameter int DATALEN    = 16,
  parameter int ACCLEN     = 24,
  parameter int NACC       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            s_axis_prod_tvalid,
  input  logic [2*DATALEN-1:0]            s_axis_prod_tdata,
  output logic                            m_axis_sum_tvalid,
  input  logic                            m_axis_sum_tready,
  output logic [2*ACCLEN-1:0]             m_axis_sum_tdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int CW = (NACC > 1) ? $clog2(NACC) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_TERM = CW'(NACC - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic SINGLE_TERM = (NACC == 1);

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  logic [2*ACCLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*ACCLEN-1:0] sum_w;
  logic                first_term;
  logic                complete;

  // A clear on the same cycle as a beat restarts the sum with that beat.
  assign first_term = clr || (cnt_q == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [ACCLEN-1:0] ext;
      logic signed [ACCLEN-1:0] base;
      assign ext  = ACCLEN'($signed(s_axis_prod_tdata[gi*DATALEN +: DATALEN]));
      assign base = first_term ? '0 : $signed(acc_q[gi*ACCLEN +: ACCLEN]);
      assign sum_w[gi*ACCLEN +: ACCLEN] = base + ext;
    end
  endgenerate

  assign complete = s_axis_prod_tvalid &&
                    (clr ? SINGLE_TERM : (cnt_q == LAST_TERM));

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (s_axis_prod_tvalid) begin
      acc_d = sum_w;
      if (complete) begin
        cnt_d = '0;
      end else if (first_term) begin
        cnt_d = CW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT output FIFO
  // ---------------------------------------------------------------------------
  logic [2*ACCLEN-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                overflow_q, overflow_d;
  logic                full;
  logic                pop;
  logic                push_ok;

  assign full    = (level_q == FULL_LEVEL);
  assign pop     = m_axis_sum_tvalid && m_axis_sum_tready;
  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign push_ok = complete && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else if (complete) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; the output mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= sum_w;
    end
  end

  assign m_axis_sum_tvalid = (level_q != '0);
  assign m_axis_sum_tdata  = m_axis_sum_tvalid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level        = level_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_cmpmul_acc_collector.sv
// Directed plus random stimulus against a queue-based model of the collector;
// a second instance with ACCLEN=17 shares the stimulus to check wrap-around.
module tb_cmpmul_acc_collector;

  localparam int DL    = 16;
  localparam int AL    = 24;
  localparam int AL17  = 17;
  localparam int NACC  = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              s_tvalid = 1'b0;
  logic [2*DL-1:0]   s_tdata = '0;
  logic              m_tready = 1'b0;
  logic              m_tvalid;
  logic [2*AL-1:0]   m_tdata;
  logic [2:0]        level;
  logic              ovf;
  logic              m_tvalid17;
  logic [2*AL17-1:0] m_tdata17;
  logic [2:0]        level17;
  logic              ovf17;

  int checks = 0;
  int errors = 0;

  // model state
  int  terms_re[$];
  int  terms_im[$];
  int  q_re[$];
  int  q_im[$];
  bit  m_ovf = 1'b0;

  always #5 clk = ~clk;

  cmpmul_acc_collector #(.DATALEN(DL), .ACCLEN(AL), .NACC(NACC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_prod_tvalid(s_tvalid), .s_axis_prod_tdata(s_tdata),
    .m_axis_sum_tvalid(m_tvalid), .m_axis_sum_tready(m_tready),
    .m_axis_sum_tdata(m_tdata), .fifo_level(level), .overflow(ovf)
  );

  cmpmul_acc_collector #(.DATALEN(DL), .ACCLEN(AL17), .NACC(NACC), .FIFO_DEPTH(DEPTH)) dut17 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_prod_tvalid(s_tvalid), .s_axis_prod_tdata(s_tdata),
    .m_axis_sum_tvalid(m_tvalid17), .m_axis_sum_tready(m_tready),
    .m_axis_sum_tdata(m_tdata17), .fifo_level(level17), .overflow(ovf17)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one clock edge, from the pre-edge model state.
  task automatic model_edge(input bit v, input int re, input int im, input bit c,
                            input bit r, input bit rs);
    bit pop;
    bit done;
    int sre;
    int sim;
    if (rs) begin
      terms_re.delete(); terms_im.delete();
      q_re.delete(); q_im.delete();
      m_ovf = 1'b0;
      return;
    end
    pop  = (q_re.size() != 0) && r;
    done = 1'b0;
    sre  = 0;
    sim  = 0;
    if (c) begin
      terms_re.delete(); terms_im.delete();
    end
    if (v) begin
      terms_re.push_back(re);
      terms_im.push_back(im);
      if (terms_re.size() == NACC) begin
        foreach (terms_re[i]) begin
          sre += terms_re[i];
          sim += terms_im[i];
        end
        terms_re.delete(); terms_im.delete();
        done = 1'b1;
      end
    end
    if (pop) begin
      void'(q_re.pop_front());
      void'(q_im.pop_front());
    end
    if (done) begin
      if (q_re.size() == DEPTH) m_ovf = 1'b1;
      else begin
        q_re.push_back(sre);
        q_im.push_back(sim);
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] hre;
    logic [31:0] him;
    logic [2*AL-1:0]   exp24;
    logic [2*AL17-1:0] exp17;
    chk("tvalid", 64'(m_tvalid), 64'(q_re.size() != 0));
    chk("level", 64'(level), 64'(q_re.size()));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("level17", 64'(level17), 64'(q_re.size()));
    chk("overflow17", 64'(ovf17), 64'(m_ovf));
    if (q_re.size() != 0) begin
      hre   = q_re[0];
      him   = q_im[0];
      exp24 = {him[AL-1:0], hre[AL-1:0]};
      exp17 = {him[AL17-1:0], hre[AL17-1:0]};
      chk("tdata", 64'(m_tdata), 64'(exp24));
      chk("tdata17", 64'(m_tdata17), 64'(exp17));
      chk("tvalid17", 64'(m_tvalid17), 64'd1);
    end
  endtask

  task automatic step(input bit v, input int re, input int im, input bit c,
                      input bit r, input bit rs);
    logic [31:0] lre;
    logic [31:0] lim;
    lre      = re;
    lim      = im;
    s_tvalid = v;
    s_tdata  = {lim[DL-1:0], lre[DL-1:0]};
    clr      = c;
    m_tready = r;
    rst      = rs;
    @(posedge clk);
    model_edge(v, re, im, c, r, rs);
    #1;
    check_outputs();
    if (rs) begin
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    end
  endtask

  task automatic beat(input int re, input int im, input bit r);
    step(1'b1, re, im, 1'b0, r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, r, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();

    // 1: back-to-back beats, sum re=10 im=-4
    for (int k = 1; k <= 4; k++) beat(k, -1, 1'b1);
    idle(3, 1'b1);

    // 2: same beats with idle gaps
    for (int k = 1; k <= 4; k++) begin
      beat(k, -1, 1'b1);
      idle(1 + (k % 3), 1'b1);
    end
    idle(2, 1'b1);

    // 3: stalled output, five sums into a four-deep FIFO, then drain
    for (int k = 1; k <= 20; k++) beat(k, 0, 1'b0);
    chk("ovf_after_5", 64'(ovf), 64'd1);
    chk("level_full", 64'(level), 64'd4);
    idle(6, 1'b1);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // 4: sign extension and wrap
    do_reset();
    for (int k = 0; k < 4; k++) beat(-32768, 0, 1'b1);
    idle(2, 1'b1);
    for (int k = 0; k < 4; k++) beat(32767, 32767, 1'b1);
    idle(2, 1'b1);
    // full FIFO with a pop on the same edge as a completing beat
    for (int k = 0; k < 16; k++) beat(k * 100 - 700, 3 - k, 1'b0);
    for (int k = 0; k < 3; k++) beat(11, 22, 1'b0);
    beat(11, 22, 1'b1);
    chk("full_push_pop_ovf", 64'(ovf), 64'd0);
    chk("full_push_pop_level", 64'(level), 64'd4);
    idle(6, 1'b1);

    // 5: clr discarding a partial sum, and clr together with a beat
    beat(9, 0, 1'b1);
    beat(9, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) beat(5, 0, 1'b1);
    idle(2, 1'b1);
    beat(1, 1, 1'b1);
    step(1'b1, 7, 0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) beat(3, 0, 1'b1);
    idle(2, 1'b1);

    // 6: reset with sums queued and a partial sum in flight
    for (int k = 0; k < 10; k++) beat(k + 1, -k, 1'b0);
    chk("queued_two", 64'(level), 64'd2);
    step(1'b1, 5, 5, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) beat(1, 0, 1'b1);
    idle(2, 1'b1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 249) == 0);
    end
    idle(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
